// File: rtl/dmem_uart_tx_pkg.sv
// dmem_uart_tx_pkg: register map, STATUS bit positions and TX FSM states (UART_TX_PARITY_EN adds PARITY)
package dmem_uart_tx_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 7;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: data-bus mapped UART transmitter (8N1; 8E1 when UART_TX_PARITY_EN is defined)
module dmem_uart_tx
  import dmem_uart_tx_pkg::*;
#(
  parameter int               AWIDTH     = 14,
  parameter int               XLEN       = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 'h3F00,
  parameter int               FIFO_DEPTH = 8,
  parameter logic [15:0]      DIV_RESET  = 16'd868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic [XLEN-1:0]   qin,
  input  logic [3:0]        we,
  output logic [XLEN-1:0]   qout,
  output logic              txd,
  output logic              irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam state_t POST_DATA = S_PARITY;
`else
  localparam state_t POST_DATA = S_STOP;
`endif
  logic sel, wr_tx, wr_st, wr_div, full, empty, pop, ovf, par, bit_done, unused;
  logic [1:0] off;
  logic [7:0] fifo_q, sh;
  logic [CW-1:0] count;
  logic [15:0] bauddiv, div_eff, div_lat, cnt;
  logic [2:0] bit_idx;
  logic [XLEN-1:0] rdata;
  state_t state;
  assign sel = addr[AWIDTH-1:4] == BASE_ADDR[AWIDTH-1:4];
  assign off = addr[3:2];
  assign wr_tx = sel & (off == REG_TXDATA) & we[0];
  assign wr_st = sel & (off == REG_STATUS) & we[0] & qin[ST_OVF];
  assign wr_div = sel & (off == REG_BAUDDIV);
  assign div_eff = eff_div(bauddiv);
  assign bit_done = cnt == 16'd0;
  // the head is popped straight from IDLE or at the end of STOP, so frames run back-to-back
  assign pop = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
  assign irq = empty & (state == S_IDLE);
  assign rdata = (off == REG_STATUS) ? XLEN'({count, 3'b000, ovf, state != S_IDLE, empty, full}) :
                 (off == REG_BAUDDIV) ? XLEN'(bauddiv) : '0;
  assign unused = ^{qin[XLEN-1:16], we[3:2], addr[1:0]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_tx), .wdata(qin[7:0]), .pop(pop),
    .rdata(fifo_q), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
      ovf <= 1'b0;
      bauddiv <= DIV_RESET;
    end else begin
      qout <= sel ? rdata : '0;
      ovf <= (wr_tx & full) | (ovf & ~wr_st);
      if (wr_div & we[0]) bauddiv[7:0] <= qin[7:0];
      if (wr_div & we[1]) bauddiv[15:8] <= qin[15:8];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      txd <= 1'b1;
      cnt <= '0;
      div_lat <= 16'd1;
      sh <= '0;
      par <= 1'b0;
      bit_idx <= '0;
    end else if (pop) begin
      state <= S_START;
      txd <= 1'b0;
      sh <= fifo_q;
      par <= ^fifo_q;
      div_lat <= div_eff;
      cnt <= div_eff - 16'd1;
    end else if (state != S_IDLE) begin
      cnt <= bit_done ? div_lat - 16'd1 : cnt - 16'd1;
      if (bit_done) begin
        case (state)
          S_START: begin
            state <= S_DATA;
            txd <= sh[0];
            sh <= sh >> 1;
            bit_idx <= 3'd0;
          end
          S_DATA: begin
            state <= (bit_idx == 3'd7) ? POST_DATA : S_DATA;
            txd <= (bit_idx == 3'd7) ? ((POST_DATA == S_STOP) | par) : sh[0];
            sh <= sh >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state <= S_STOP;
            txd <= 1'b1;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
